instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Program-counter and IF/ID register stage driving the combinational instruction memory.
//  Owns the PC, presents it as the byte address pc_o, captures the returned word into IF/ID.
//  Handles stall, branch/jump redirect, out-of-range halt and a retired-fetch counter.
//  Sits between the hazard/branch logic (upstream control) and the decoder (downstream).
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  IMEM_WORDS 32             instruction memory depth in 32-bit words; valid PC < IMEM_WORDS*4
// PORTS
//  clk_i            in   1   clock, rising edge
//  rst_i            in   1   asynchronous reset, active-low
//  stall_i          in   1   hold PC and IF/ID (load-use hazard)
//  redirect_i       in   1   branch taken / jump: load redirect_pc_i
//  redirect_pc_i    in   32  redirect target byte address
//  instr_i          in   32  word read from instruction memory at pc_o (same cycle)
//  pc_o             out  32  current PC = instruction memory byte address
//  ifid_pc4_o       out  32  IF/ID: PC+4 of captured instruction
//  ifid_instr_o     out  32  IF/ID: captured instruction (32'h0 = bubble)
//  ifid_valid_o     out  1   IF/ID: captured instruction is real
//  halted_o         out  1   high while in HALT
//  misalign_o       out  1   one-cycle pulse: redirect target had addr[1:0]!=0
//  fetch_cnt_o      out  32  number of valid IF/ID captures since reset
// BEHAVIOUR
//  Reset (rst_i=0, async): pc_o=RESET_PC; ifid_* =0; halted_o=0; misalign_o=0;
//   fetch_cnt_o=0; state=BOOT. Reset mid-operation discards in-flight IF/ID content.
//  States: BOOT, RUN, HALT. All transitions on rising clk_i.
//  BOOT: exactly one cycle after reset release; no capture, PC unchanged -> RUN.
//  RUN, per cycle, priority redirect_i > stall_i > normal:
//   redirect_i: pc<=redirect_pc_i & ~32'h3; IF/ID<=bubble (pc4=0,instr=0,valid=0);
//    misalign_o=1 next cycle iff redirect_pc_i[1:0]!=0. Redirect wins over simultaneous stall.
//   stall_i: pc and all IF/ID outputs hold; counter holds.
//   normal: IF/ID<={pc+4, instr_i, 1}; pc<=pc+4; fetch_cnt_o+=1.
//  Range check: if next PC (any source) >= IMEM_WORDS*4 -> HALT next cycle; the word at the
//   last valid PC is still captured in the same cycle that PC advances out of range.
//  HALT: halted_o=1; pc holds; IF/ID<=bubble each cycle unless stall_i (then holds);
//   redirect_i to in-range target -> RUN with pc<=target; out-of-range redirect stays HALT.
//  Latency: instruction at PC p is on ifid_instr_o one cycle after pc_o==p (no stall).
//  Arithmetic: pc+4 modulo 2^32; fetch_cnt_o saturates at 32'hFFFF_FFFF.
//  misalign_o is registered, high one cycle, otherwise 0.
// TESTING
//  1 Reset then run 4 cycles, imem words A,B,C,D -> BOOT cycle, then ifid_instr_o=A,B,C
//    with ifid_pc4_o=4,8,12; fetch_cnt_o=3.
//  2 stall_i high 2 cycles at pc_o=8 -> pc_o=8 and ifid_instr_o=B held 2 cycles, cnt unchanged.
//  3 redirect_i with redirect_pc_i=0x14 and stall_i same cycle -> pc_o=0x14, IF/ID bubble,
//    valid=0; next cycle captures word 5.
//  4 redirect_pc_i=0x1A -> pc_o=0x18, misalign_o high exactly one cycle.
//  5 IMEM_WORDS=32, run from 0x78 -> word 30,31 captured, halted_o=1 with pc_o=0x80;
//    redirect to 0x0 -> halted_o=0, RUN resumes from word 0.
//  6 Assert rst_i=0 mid-run at pc_o=0x40 -> all outputs zero/RESET_PC asynchronously.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC and presents it to a combinational instruction
// memory. It captures the returned word into the IF/ID register. It also
// handles stall, redirect, the out-of-range halt and a saturating count of
// retired fetches.
//
// Control inputs are level-sampled on every rising clock edge; there is no
// valid/ready handshake. stall_i and redirect_i act in the cycle they are
// high. redirect_i wins over stall_i. Both are ignored in the BOOT cycle.
// instr_i must be the memory word at pc_o in that same cycle.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic        halted_o,
  output logic        misalign_o,
  output logic [31:0] fetch_cnt_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // The first byte address past the memory. It is one bit wider so that a
  // huge depth cannot wrap.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic [31:0] redirect_tgt;
  logic [31:0] pc_plus4;
  logic        tgt_in_range;
  logic        seq_in_range;

  // Candidate next PCs and their range checks. A redirect target is
  // word-aligned by dropping its low two bits.
  always_comb begin
    redirect_tgt = {redirect_pc_i[31:2], 2'b00};
    pc_plus4     = pc_q + 32'd4;
    tgt_in_range = ({1'b0, redirect_tgt} < PC_LIMIT);
    seq_in_range = ({1'b0, pc_plus4} < PC_LIMIT);
  end

  // State register plus every datapath flop, all cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      misalign_q   <= misalign_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  // Next-state logic. Any PC leaving the memory range moves to HALT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (redirect_i)   state_d = tgt_in_range ? ST_RUN : ST_HALT;
        else if (!stall_i) state_d = seq_in_range ? ST_RUN : ST_HALT;
      end
      ST_HALT: begin
        if (redirect_i && tgt_in_range) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Datapath next values. By default everything holds and misalign drops.
  always_comb begin
    pc_d         = pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    misalign_d   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (redirect_i) begin
          pc_d         = redirect_tgt;
          ifid_pc4_d   = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
          misalign_d   = |redirect_pc_i[1:0];
        end else if (!stall_i) begin
          pc_d         = pc_plus4;
          ifid_pc4_d   = pc_plus4;
          ifid_instr_d = instr_i;
          ifid_valid_d = 1'b1;
          if (fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end
      ST_HALT: begin
        // The PC only moves when a redirect brings it back into range.
        if (redirect_i) begin
          if (tgt_in_range) pc_d = redirect_tgt;
          ifid_pc4_d   = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
          misalign_d   = |redirect_pc_i[1:0];
        end else if (!stall_i) begin
          ifid_pc4_d   = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs: registered values, plus status decoded from the state.
  always_comb begin
    pc_o         = pc_q;
    ifid_pc4_o   = ifid_pc4_q;
    ifid_instr_o = ifid_instr_q;
    ifid_valid_o = ifid_valid_q;
    misalign_o   = misalign_q;
    fetch_cnt_o  = fetch_cnt_q;
    halted_o     = (state_q == ST_HALT);
    dbg_state_o  = state_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit. It runs a directed sequence with literal
// expectations, then a random run. A behavioural model predicts every
// output after every clock edge.
module tb_instr_fetch_unit;

  localparam int unsigned WORDS = 32;
  localparam logic [31:0] LIMIT = 32'd128;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] instr_i;
  logic [31:0] pc_o, ifid_pc4_o, ifid_instr_o, fetch_cnt_o;
  logic        ifid_valid_o, halted_o, misalign_o;
  logic [1:0]  dbg_state_o;

  logic [31:0] mem [WORDS];

  // Combinational instruction memory. Out-of-range reads return a marker word.
  assign instr_i = (pc_o < LIMIT) ? mem[pc_o[6:2]] : 32'hDEAD_BEEF;

  instr_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .instr_i(instr_i), .pc_o(pc_o),
    .ifid_pc4_o(ifid_pc4_o), .ifid_instr_o(ifid_instr_o),
    .ifid_valid_o(ifid_valid_o), .halted_o(halted_o), .misalign_o(misalign_o),
    .fetch_cnt_o(fetch_cnt_o), .dbg_state_o(dbg_state_o)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_pc4, m_instr, m_cnt;
  bit          m_valid, m_halt, m_boot, m_mis;

  function automatic void model_reset();
    m_pc = 32'h0; m_pc4 = '0; m_instr = '0; m_cnt = '0;
    m_valid = 0; m_halt = 0; m_boot = 1; m_mis = 0;
  endfunction

  function automatic void model_bubble();
    m_pc4 = '0; m_instr = '0; m_valid = 0;
  endfunction

  // Advance the model by one clock edge, given the inputs applied before it.
  function automatic void model_step(input bit st, input bit rd, input logic [31:0] rpc);
    logic [31:0] tgt;
    tgt   = rpc & ~32'h3;
    m_mis = 0;
    if (m_boot) begin
      m_boot = 0;
    end else if (rd) begin
      m_mis = (rpc[1:0] != 2'b00);
      model_bubble();
      if (!m_halt) begin
        m_pc   = tgt;
        m_halt = (tgt >= LIMIT);
      end else if (tgt < LIMIT) begin
        m_pc   = tgt;
        m_halt = 0;
      end
    end else if (st) begin
      // Everything holds.
    end else if (!m_halt) begin
      m_instr = mem[m_pc[6:2]];
      m_pc    = m_pc + 32'd4;
      m_pc4   = m_pc;
      m_valid = 1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      m_halt  = (m_pc >= LIMIT);
    end else begin
      model_bubble();
    end
  endfunction

  // ---------------- scoreboard / checks ----------------
  task automatic cmp_model(input string name);
    tests++;
    if (pc_o !== m_pc || ifid_pc4_o !== m_pc4 || ifid_instr_o !== m_instr ||
        ifid_valid_o !== m_valid || halted_o !== m_halt || misalign_o !== m_mis ||
        fetch_cnt_o !== m_cnt) begin
      fails++;
      $display("FAIL %s t=%0t: got pc=%h pc4=%h instr=%h v=%b h=%b mis=%b cnt=%0d; want pc=%h pc4=%h instr=%h v=%b h=%b mis=%b cnt=%0d",
               name, $time, pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o, halted_o, misalign_o,
               fetch_cnt_o, m_pc, m_pc4, m_instr, m_valid, m_halt, m_mis, m_cnt);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge. Outputs are checked
  // 1 time unit after the next rising edge.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
    model_step(st, rd, rpc);
    @(posedge clk_i); #1;
    cmp_model("cycle");
  endtask

  task automatic async_reset();
    rst_i = 1'b0; #1;
    model_reset();
    cmp_model("async_reset");
    @(posedge clk_i); #1;
    rst_i = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 32'hA000_0000 + i;
    model_reset();
    #1;
    cmp_model("reset_state");
    chk("reset_pc", pc_o, 32'h0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b1;

    // Directed fetch: one BOOT cycle, then sequential captures.
    step(0, 0, 0);
    chk("boot_valid", {31'b0, ifid_valid_o}, 32'd0);
    chk("boot_pc", pc_o, 32'h0);
    step(0, 0, 0);
    chk("t1_instr_a", ifid_instr_o, 32'hA000_0000);
    chk("t1_pc4_a", ifid_pc4_o, 32'd4);
    step(0, 0, 0);
    chk("t1_pc", pc_o, 32'd8);
    step(0, 0, 0);
    chk("t1_instr_c", ifid_instr_o, 32'hA000_0002);
    chk("t1_pc4_c", ifid_pc4_o, 32'd12);
    chk("t1_cnt", fetch_cnt_o, 32'd3);

    // A two-cycle stall holds the PC, IF/ID and the count.
    step(1, 0, 0);
    step(1, 0, 0);
    chk("t2_pc", pc_o, 32'd12);
    chk("t2_instr", ifid_instr_o, 32'hA000_0002);
    chk("t2_cnt", fetch_cnt_o, 32'd3);

    // A redirect with a simultaneous stall: the redirect wins.
    step(1, 1, 32'h14);
    chk("t3_pc", pc_o, 32'h14);
    chk("t3_valid", {31'b0, ifid_valid_o}, 32'd0);
    step(0, 0, 0);
    chk("t3_instr5", ifid_instr_o, 32'hA000_0005);

    // A misaligned redirect target: PC aligned, one-cycle misalign pulse.
    step(0, 1, 32'h1A);
    chk("t4_pc", pc_o, 32'h18);
    chk("t4_mis_hi", {31'b0, misalign_o}, 32'd1);
    step(0, 0, 0);
    chk("t4_mis_lo", {31'b0, misalign_o}, 32'd0);

    // Running off the end of memory, then recovering with a redirect.
    step(0, 1, 32'h78);
    step(0, 0, 0);
    chk("t5_w30", ifid_instr_o, 32'hA000_001E);
    step(0, 0, 0);
    chk("t5_w31", ifid_instr_o, 32'hA000_001F);
    chk("t5_halt", {31'b0, halted_o}, 32'd1);
    chk("t5_pc", pc_o, 32'h80);
    step(0, 0, 0);
    chk("t5_bubble", {31'b0, ifid_valid_o}, 32'd0);
    step(0, 1, 32'h0);
    chk("t5_resume", {31'b0, halted_o}, 32'd0);
    step(0, 0, 0);
    chk("t5_w0", ifid_instr_o, 32'hA000_0000);

    // Asynchronous reset mid-run.
    step(0, 1, 32'h40);
    #2;
    async_reset();
    chk("t6_pc", pc_o, 32'h0);
    chk("t6_cnt", fetch_cnt_o, 32'd0);

    // Random run with fresh memory contents.
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1) begin
        async_reset();
      end else if (r < 12) begin
        step($urandom_range(0, 1), 1, $urandom_range(0, 160));
      end else if (r < 32) begin
        step(1, 0, $urandom);
      end else begin
        step(0, 0, $urandom);
      end
    end

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
